// File: rtl/truth_table_checker_pkg.sv
// ============================================================================
// truth_table_checker_pkg : shared FSM encoding and default sweep parameters
// Revision: 1.0
// ============================================================================
`default_nettype none

package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned c_DEFAULT_SETTLE   = 2;
    localparam logic [7:0]  c_DEFAULT_EXPECTED = 8'h96;
    localparam logic [2:0]  c_LAST_VECTOR      = 3'd7;

endpackage

`default_nettype wire

// File: rtl/truth_table_checker_settle_timer.sv
// ============================================================================
// tt_settle_timer : counts settle cycles while enabled, flags SETTLE-1 reached
// Revision: 1.0
// ============================================================================
`default_nettype none

module tt_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    assign expired = (count_q == 4'(SETTLE - 1));

    // Holding at the terminal value keeps the count from wrapping if enable lingers.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (enable && !expired) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// truth_table_checker : sweeps all 3-bit vectors into a combinational unit and
// compares each sampled response against a golden truth table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int unsigned SETTLE   = c_DEFAULT_SETTLE,
    parameter logic [7:0]  EXPECTED = c_DEFAULT_EXPECTED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       x2,
    output logic       x1,
    output logic       x0,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_idx
);

    state_t     state_q;
    logic [2:0] idx_q;
    logic [2:0] vec_q;
    logic [7:0] captured_q;
    logic [3:0] fail_count_q;
    logic [2:0] first_fail_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic       w_expired;
    logic       w_mismatch;

    assign w_mismatch = z ^ EXPECTED[idx_q];

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != ST_HOLD),
        .enable  (state_q == ST_HOLD),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            vec_q        <= 3'd0;
            captured_q   <= 8'd0;
            fail_count_q <= 4'd0;
            first_fail_q <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_HOLD;
                        idx_q        <= 3'd0;
                        vec_q        <= 3'd0;
                        captured_q   <= 8'd0;
                        fail_count_q <= 4'd0;
                        first_fail_q <= 3'd0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_expired) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    captured_q[idx_q] <= z;
                    if (w_mismatch) begin
                        fail_count_q <= fail_count_q + 4'd1;
                        if (fail_count_q == 4'd0) begin
                            first_fail_q <= idx_q;
                        end
                    end
                    if (idx_q == c_LAST_VECTOR) begin
                        state_q <= ST_DONE;
                        vec_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count_q == 4'd0) && !w_mismatch;
                    end else begin
                        state_q <= ST_HOLD;
                        idx_q   <= idx_q + 3'd1;
                        vec_q   <= idx_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign {x2, x1, x0}   = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign captured       = captured_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// tb_truth_table_checker : randomized self-checking bench, SETTLE=2 and SETTLE=1
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, start_a, z_a, x2_a, x1_a, x0_a, busy_a, done_a, pass_a;
    logic [7:0] cap_a, tt_a;
    logic [3:0] fc_a;
    logic [2:0] ffi_a;

    logic       rst_n_b, start_b, z_b, x2_b, x1_b, x0_b, busy_b, done_b, pass_b;
    logic [7:0] cap_b, tt_b;
    logic [3:0] fc_b;
    logic [2:0] ffi_b;

    logic [7:0] golden;
    int n_checks = 0;
    int n_fail   = 0;

    // Unit under test: an arbitrary truth table looked up by the driven vector
    assign z_a = tt_a[{x2_a, x1_a, x0_a}];
    assign z_b = tt_b[{x2_b, x1_b, x0_b}];

    truth_table_checker u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
        .x2(x2_a), .x1(x1_a), .x0(x0_a), .z(z_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .captured(cap_a), .fail_count(fc_a), .first_fail_idx(ffi_a)
    );

    truth_table_checker #(.SETTLE(1), .EXPECTED(8'h96)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b),
        .x2(x2_b), .x1(x1_b), .x0(x0_b), .z(z_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .captured(cap_b), .fail_count(fc_b), .first_fail_idx(ffi_b)
    );

    function automatic logic [2:0] get_x(input int w);
        return (w != 0) ? {x2_b, x1_b, x0_b} : {x2_a, x1_a, x0_a};
    endfunction
    function automatic logic get_done(input int w);
        return (w != 0) ? done_b : done_a;
    endfunction
    function automatic logic get_busy(input int w);
        return (w != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic get_pass(input int w);
        return (w != 0) ? pass_b : pass_a;
    endfunction
    function automatic logic [7:0] get_cap(input int w);
        return (w != 0) ? cap_b : cap_a;
    endfunction
    function automatic logic [3:0] get_fc(input int w);
        return (w != 0) ? fc_b : fc_a;
    endfunction
    function automatic logic [2:0] get_ffi(input int w);
        return (w != 0) ? ffi_b : ffi_a;
    endfunction

    task automatic drive_start(input int w, input logic v);
        if (w != 0) start_b = v;
        else        start_a = v;
    endtask

    // Reference: results follow directly from comparing the table with golden
    function automatic void model(input logic [7:0] tt, output logic [3:0] fcnt,
                                  output logic [2:0] first, output logic ok);
        fcnt  = 4'd0;
        first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (tt[i] !== golden[i]) begin
                fcnt  = fcnt + 4'd1;
                first = 3'(i);
            end
        end
        ok = (fcnt == 4'd0);
    endfunction

    // Pulses start, then follows the sweep: n counts edges after the start edge.
    task automatic run_sweep(input int w, input int restart_at, output int lat,
                             output bit seq_ok, output logic d0, output logic [7:0] c0);
        int per;
        per = (w != 0) ? 2 : 3;
        @(negedge clk);
        drive_start(w, 1'b1);
        @(negedge clk);
        drive_start(w, 1'b0);
        d0     = get_done(w);
        c0     = get_cap(w);
        seq_ok = 1'b1;
        lat    = -1;
        for (int n = 0; n <= 200; n++) begin
            if (get_done(w)) begin
                lat = n;
                break;
            end
            if (get_x(w) !== 3'(n / per) || get_busy(w) !== 1'b1) seq_ok = 1'b0;
            drive_start(w, n == restart_at);
            @(negedge clk);
        end
        drive_start(w, 1'b0);
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        start_a = 1'b1; start_b = 1'b1;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if ({get_busy(w), get_done(w), get_pass(w), get_x(w)} !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b want 000000", w,
                         {get_busy(w), get_done(w), get_pass(w), get_x(w)});
            end
            n_checks++;
            if ({get_cap(w), get_fc(w), get_ffi(w)} !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_results[%0d]: got %h want 0", w,
                         {get_cap(w), get_fc(w), get_ffi(w)});
            end
        end
        start_a = 1'b0; start_b = 1'b0;
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy_a, busy_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_priority: busy got %b want 00", {busy_a, busy_b});
        end
    endtask

    task automatic test_parity();
        int lat; bit sq; logic d0; logic [7:0] c0;
        tt_a = 8'h96;
        run_sweep(0, -1, lat, sq, d0, c0);
        n_checks++;
        if (lat !== 24) begin n_fail++; $display("FAIL parity_latency: got %0d want 24", lat); end
        n_checks++;
        if (sq !== 1'b1) begin n_fail++; $display("FAIL parity_vector_order: got %0d want 1", sq); end
        n_checks++;
        if ({cap_a, fc_a, ffi_a, pass_a, busy_a} !== {8'h96, 4'd0, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL parity_results: got cap=%h fc=%0d ffi=%0d pass=%b busy=%b want 96/0/0/1/0",
                     cap_a, fc_a, ffi_a, pass_a, busy_a);
        end
        n_checks++;
        if (x2_a !== 1'b0 || x1_a !== 1'b0 || x0_a !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_idle_vector: got %b want 000", {x2_a, x1_a, x0_a});
        end
    endtask

    task automatic test_stuck_zero();
        int lat; bit sq; logic d0; logic [7:0] c0;
        tt_a = 8'h00;
        run_sweep(0, -1, lat, sq, d0, c0);
        n_checks++;
        if ({cap_a, fc_a, ffi_a, pass_a} !== {8'h00, 4'd4, 3'd1, 1'b0} || lat !== 24) begin
            n_fail++;
            $display("FAIL stuck_zero: got cap=%h fc=%0d ffi=%0d pass=%b lat=%0d want 00/4/1/0/24",
                     cap_a, fc_a, ffi_a, pass_a, lat);
        end
    endtask

    task automatic test_random_tables(input int w, input int iters);
        int lat; bit sq; logic d0; logic [7:0] c0;
        logic [7:0] tt; logic [3:0] efc; logic [2:0] effi; logic eok;
        for (int k = 0; k < iters; k++) begin
            tt = 8'($urandom);
            if (w != 0) tt_b = tt;
            else        tt_a = tt;
            model(tt, efc, effi, eok);
            run_sweep(w, -1, lat, sq, d0, c0);
            n_checks++;
            if ({get_cap(w), get_fc(w), get_ffi(w), get_pass(w)} !== {tt, efc, effi, eok}) begin
                n_fail++;
                $display("FAIL random_table[%0d] tt=%h: got cap=%h fc=%0d ffi=%0d pass=%b want %h/%0d/%0d/%b",
                         w, tt, get_cap(w), get_fc(w), get_ffi(w), get_pass(w), tt, efc, effi, eok);
            end
            n_checks++;
            if (lat !== ((w != 0) ? 16 : 24) || sq !== 1'b1) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: got lat=%0d order=%0d want %0d/1",
                         w, lat, sq, (w != 0) ? 16 : 24);
            end
        end
    endtask

    task automatic test_settle1();
        int lat; bit sq; logic d0; logic [7:0] c0;
        tt_b = 8'h96;
        run_sweep(1, -1, lat, sq, d0, c0);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL settle1_latency: got %0d want 16", lat); end
        n_checks++;
        if (sq !== 1'b1) begin n_fail++; $display("FAIL settle1_vector_order: got %0d want 1", sq); end
        n_checks++;
        if ({cap_b, fc_b, pass_b} !== {8'h96, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL settle1_results: got cap=%h fc=%0d pass=%b want 96/0/1", cap_b, fc_b, pass_b);
        end
    endtask

    task automatic test_restart_ignored();
        int lat; bit sq; logic d0; logic [7:0] c0;
        tt_a = 8'h96;
        run_sweep(0, 5, lat, sq, d0, c0);
        n_checks++;
        if (lat !== 24 || sq !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ignored_timing: got lat=%0d order=%0d want 24/1", lat, sq);
        end
        n_checks++;
        if ({cap_a, fc_a, ffi_a, pass_a} !== {8'h96, 4'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_ignored_results: got cap=%h fc=%0d ffi=%0d pass=%b want 96/0/0/1",
                     cap_a, fc_a, ffi_a, pass_a);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int lat; bit sq; logic d0; logic [7:0] c0; bit saw_done;
        tt_a = 8'h96;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if ({x2_a, x1_a, x0_a} !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_reset_vector: got %0d want 3", {x2_a, x1_a, x0_a});
        end
        rst_n_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        n_checks++;
        if ({busy_a, done_a, pass_a, x2_a, x1_a, x0_a, cap_a, fc_a, ffi_a} !== 21'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got %h want 0",
                     {busy_a, done_a, pass_a, x2_a, x1_a, x0_a, cap_a, fc_a, ffi_a});
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_a || busy_a) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_quiet: got %0d want 0", saw_done); end
        run_sweep(0, -1, lat, sq, d0, c0);
        n_checks++;
        if (lat !== 24 || {cap_a, fc_a, pass_a} !== {8'h96, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: got lat=%0d cap=%h fc=%0d pass=%b want 24/96/0/1",
                     lat, cap_a, fc_a, pass_a);
        end
    endtask

    task automatic test_start_in_done();
        int lat; bit sq; logic d0; logic [7:0] c0;
        tt_a = 8'h96;
        n_checks++;
        if (done_a !== 1'b1 || cap_a !== 8'h96) begin
            n_fail++;
            $display("FAIL done_before_restart: got done=%b cap=%h want 1/96", done_a, cap_a);
        end
        run_sweep(0, -1, lat, sq, d0, c0);
        n_checks++;
        if (d0 !== 1'b0 || c0 !== 8'h00) begin
            n_fail++;
            $display("FAIL restart_clears: got done=%b cap=%h want 0/00", d0, c0);
        end
        n_checks++;
        if (lat !== 24 || {cap_a, fc_a, ffi_a, pass_a} !== {8'h96, 4'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_second_sweep: got lat=%0d cap=%h fc=%0d pass=%b want 24/96/0/1",
                     lat, cap_a, fc_a, pass_a);
        end
    endtask

    initial begin
        golden  = 8'h96;
        tt_a    = 8'h00;
        tt_b    = 8'h00;
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        test_reset();
        test_parity();
        test_stuck_zero();
        test_random_tables(0, 6);
        test_settle1();
        test_random_tables(1, 4);
        test_restart_ignored();
        test_reset_mid_sweep();
        test_start_in_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
